dma_priority_arbiter: RTL and testbench

Four-channel request arbiter and bus-handshake sequencer for the DMA controller. It consumes the live command-register word and channel mask, resolves competing DREQ lines under fixed or rotating priority, and runs the HRQ/HLDA hold handshake with the CPU. It issues one DACK to the winning channel for the duration of its service and records terminal-count status per channel. It sits between the command/mask registers and the address/count datapath; `active_channel` selects which channel's registers drive the bus.

---
 rtl/dma_priority_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dma_priority_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter
//
// This is the four-channel DMA request arbiter and CPU hold-handshake sequencer.
// DREQ is registered once and normalised to active-high. Channels that are masked
// are dropped. The remaining requests are resolved under fixed or rotating
// priority. The winner is then walked through the HRQ/HLDA hold handshake, and one
// DACK is issued for the whole of its service.
//
// Ports
//   clk            in   system clock, rising edge
//   RESET_n        in   asynchronous active-low reset
//   command[7:0]   in   [7] DACK pol, [6] DREQ pol, [4] rotating, [2] disable
//   mask[3:0]      in   1 = channel request ignored
//   DREQ[3:0]      in   channel requests, polarity per command[6]
//   HLDA           in   CPU hold acknowledge
//   EOP_n          in   end of process / terminal count, active low
//   status_rd      in   one-cycle pulse, clears tc_status
//   HRQ            out  hold request to CPU
//   DACK[3:0]      out  channel acknowledge, polarity per command[7]
//   active_channel out  granted / pending channel index
//   busy           out  FSM not in IDLE
//   tc_status[3:0] out  sticky terminal-count flags
//
// State     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no service; arbitrate qualified requests unless disabled
// S_REQ     | winner latched, HRQ raised, waiting for HLDA
// S_GRANT   | bus held, DACK active for active_channel
// S_RELEASE | HRQ/DACK dropped, waiting for CPU to release HLDA

module dma_priority_arbiter (
    input  logic       clk,
    input  logic       RESET_n,
    input  logic [7:0] command,
    input  logic [3:0] mask,
    input  logic [3:0] DREQ,
    input  logic       HLDA,
    input  logic       EOP_n,
    input  logic       status_rd,
    output logic       HRQ,
    output logic [3:0] DACK,
    output logic [1:0] active_channel,
    output logic       busy,
    output logic [3:0] tc_status
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_GRANT   = 2'd2,
        S_RELEASE = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] dreq_q, dreq_d;
    logic [1:0] top_q, top_d;
    logic [1:0] active_q, active_d;
    logic [3:0] grant_q, grant_d;
    logic [3:0] tc_q, tc_d;

    logic [3:0] req;
    logic       any_req;
    logic [1:0] winner;

    // The register holds the request in active-high form. Its reset value of 0
    // therefore means "no request" whatever the DREQ polarity. A polarity change
    // reaches arbitration one cycle later.
    assign dreq_d  = DREQ ^ {4{~command[6]}};
    assign req     = dreq_q & ~mask;
    assign any_req = |req;

    // Rotating search starting at top_q. The loop runs from lowest priority to
    // highest, so the last match wins. top_q is 0 in fixed mode, and the same
    // search then gives fixed priority.
    always_comb begin
        winner = top_q;
        for (int i = 3; i >= 0; i--) begin
            if (req[top_q + 2'(i)]) begin
                winner = top_q + 2'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        grant_d  = grant_q;
        top_d    = top_q;
        tc_d     = status_rd ? 4'b0000 : tc_q;

        case (state_q)
            S_IDLE: begin
                if (!command[2] && any_req) begin
                    state_d  = S_REQ;
                    active_d = winner;
                end
            end
            S_REQ: begin
                if (HLDA) begin
                    state_d = S_GRANT;
                    grant_d = 4'b0001 << active_q;
                end else if (!req[active_q]) begin
                    state_d = S_RELEASE;
                end
            end
            S_GRANT: begin
                if (!EOP_n) begin
                    // If this set coincides with a status_rd clear, the set
                    // overrides the clear for this bit.
                    tc_d[active_q] = 1'b1;
                    state_d        = S_RELEASE;
                end else if (!req[active_q] || !HLDA) begin
                    state_d = S_RELEASE;
                end
                if (state_d == S_RELEASE) begin
                    grant_d = 4'b0000;
                end
            end
            S_RELEASE: begin
                if (!HLDA) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 4'b0000;
            end
        endcase

        if (state_q != S_RELEASE && state_d == S_RELEASE) begin
            top_d = active_q + 2'd1;
        end
        if (!command[4]) begin
            top_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q  <= S_IDLE;
            dreq_q   <= 4'b0000;
            top_q    <= 2'd0;
            active_q <= 2'd0;
            grant_q  <= 4'b0000;
            tc_q     <= 4'b0000;
        end else begin
            state_q  <= state_d;
            dreq_q   <= dreq_d;
            top_q    <= top_d;
            active_q <= active_d;
            grant_q  <= grant_d;
            tc_q     <= tc_d;
        end
    end

    // HRQ and DACK are decoded from registered state only. The async reset
    // therefore drops both at once.
    assign HRQ            = (state_q == S_REQ) || (state_q == S_GRANT);
    assign busy           = (state_q != S_IDLE);
    assign DACK           = grant_q ^ {4{~command[7]}};
    assign active_channel = active_q;
    assign tc_status      = tc_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed testbench for dma_priority_arbiter.
module tb_dma_priority_arbiter;

    logic       clk;
    logic       RESET_n;
    logic [7:0] command;
    logic [3:0] mask;
    logic [3:0] DREQ;
    logic       HLDA;
    logic       EOP_n;
    logic       status_rd;
    logic       HRQ;
    logic [3:0] DACK;
    logic [1:0] active_channel;
    logic       busy;
    logic [3:0] tc_status;

    int pass_cnt  = 0;
    int total_cnt = 0;

    dma_priority_arbiter dut (
        .clk            (clk),
        .RESET_n        (RESET_n),
        .command        (command),
        .mask           (mask),
        .DREQ           (DREQ),
        .HLDA           (HLDA),
        .EOP_n          (EOP_n),
        .status_rd      (status_rd),
        .HRQ            (HRQ),
        .DACK           (DACK),
        .active_channel (active_channel),
        .busy           (busy),
        .tc_status      (tc_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_hrq(input logic v, input int lim, input string tag);
        int n = 0;
        while (HRQ !== v && n < lim) begin
            tick();
            n++;
        end
        chk(tag, 8'(HRQ), 8'(v));
    endtask

    task automatic do_reset();
        RESET_n = 1'b0;
        tick();
        tick();
        RESET_n = 1'b1;
        tick();
    endtask

    logic [3:0] exp_dack;
    logic       seen_hrq;
    int         order [5] = '{0, 1, 2, 3, 0};

    initial begin
        RESET_n   = 1'b0;
        command   = 8'hC0;
        mask      = 4'b0000;
        DREQ      = 4'b0000;
        HLDA      = 1'b0;
        EOP_n     = 1'b1;
        status_rd = 1'b0;
        #3;
        chk("rst_hrq",  8'(HRQ), 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_act",  8'(active_channel), 8'h00);
        chk("rst_tc",   8'(tc_status), 8'h00);
        chk("rst_dack_hi", 8'(DACK), 8'h00);
        command = 8'h40;
        #1;
        chk("rst_dack_lo", 8'(DACK), 8'h0F);
        command = 8'hC0;
        tick();
        RESET_n = 1'b1;
        tick();

        // Fixed priority: 1010 -> channel 1 first
        DREQ = 4'b1010;
        tick();
        tick();
        chk("fix_hrq", 8'(HRQ), 8'h01);
        chk("fix_act1", 8'(active_channel), 8'h01);
        chk("fix_busy", 8'(busy), 8'h01);
        tick();
        tick();
        chk("fix_no_dack_req", 8'(DACK), 8'h00);
        HLDA = 1'b1;
        tick();
        chk("fix_dack1", 8'(DACK), 8'h02);
        EOP_n = 1'b0;
        tick();
        chk("fix_tc1", 8'(tc_status), 8'h02);
        chk("fix_rel_hrq", 8'(HRQ), 8'h00);
        chk("fix_rel_dack", 8'(DACK), 8'h00);
        EOP_n = 1'b1;
        HLDA  = 1'b0;
        DREQ  = 4'b1000;
        tick();
        chk("fix_turnaround", 8'(HRQ), 8'h00);
        tick();
        chk("fix_hrq3", 8'(HRQ), 8'h01);
        chk("fix_act3", 8'(active_channel), 8'h03);
        HLDA = 1'b1;
        tick();
        chk("fix_dack3", 8'(DACK), 8'h08);
        EOP_n = 1'b0;
        tick();
        chk("fix_tc13", 8'(tc_status), 8'h0A);
        EOP_n = 1'b1;
        HLDA  = 1'b0;
        DREQ  = 4'b0000;
        tick();
        chk("fix_idle", 8'(busy), 8'h00);

        // Rotating priority, all requesting; command[0] set and must be ignored
        command = 8'hD1;
        do_reset();
        DREQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_hrq(1'b1, 10, "rot_hrq");
            chk("rot_act", 8'(active_channel), 8'(order[k]));
            HLDA = 1'b1;
            tick();
            exp_dack = 4'b0001 << order[k];
            chk("rot_dack", 8'(DACK), 8'(exp_dack));
            EOP_n = 1'b0;
            tick();
            EOP_n = 1'b1;
            HLDA  = 1'b0;
            tick();
        end
        chk("rot_tc", 8'(tc_status), 8'h0F);
        DREQ = 4'b0000;
        wait_hrq(1'b0, 10, "rot_drain");

        // Active-low polarity and masking
        command = 8'h00;
        mask    = 4'b0001;
        DREQ    = 4'b1111;
        do_reset();
        tick();
        chk("pol_idle_dack", 8'(DACK), 8'h0F);
        chk("pol_idle_hrq", 8'(HRQ), 8'h00);
        DREQ = 4'b1100;
        wait_hrq(1'b1, 10, "pol_hrq");
        chk("pol_act", 8'(active_channel), 8'h01);
        HLDA = 1'b1;
        tick();
        chk("pol_dack", 8'(DACK), 8'h0D);
        EOP_n = 1'b0;
        tick();
        EOP_n = 1'b1;
        HLDA  = 1'b0;
        DREQ  = 4'b1111;
        tick();
        tick();
        chk("pol_after_dack", 8'(DACK), 8'h0F);
        chk("pol_after_busy", 8'(busy), 8'h00);

        // Request withdrawal in REQ
        command = 8'hC0;
        mask    = 4'b0000;
        DREQ    = 4'b0000;
        do_reset();
        DREQ = 4'b0100;
        wait_hrq(1'b1, 10, "wd_hrq");
        chk("wd_act", 8'(active_channel), 8'h02);
        DREQ = 4'b0000;
        tick();
        chk("wd_dack_a", 8'(DACK), 8'h00);
        tick();
        chk("wd_hrq_fall", 8'(HRQ), 8'h00);
        chk("wd_dack_b", 8'(DACK), 8'h00);
        tick();
        chk("wd_idle", 8'(busy), 8'h00);

        // Disable during GRANT
        DREQ = 4'b0001;
        wait_hrq(1'b1, 10, "dis_hrq");
        HLDA = 1'b1;
        tick();
        chk("dis_dack", 8'(DACK), 8'h01);
        command = 8'hC4;
        tick();
        chk("dis_still_grant", 8'(DACK), 8'h01);
        EOP_n = 1'b0;
        tick();
        chk("dis_tc", 8'(tc_status), 8'h01);
        EOP_n = 1'b1;
        HLDA  = 1'b0;
        seen_hrq = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            seen_hrq = seen_hrq | HRQ;
        end
        chk("dis_no_hrq", 8'(seen_hrq), 8'h00);
        command = 8'hC0;
        wait_hrq(1'b1, 10, "dis_reenable");

        // Reset in the middle of GRANT
        HLDA = 1'b1;
        tick();
        chk("mid_dack", 8'(DACK), 8'h01);
        RESET_n = 1'b0;
        #1;
        chk("mid_rst_hrq", 8'(HRQ), 8'h00);
        chk("mid_rst_dack", 8'(DACK), 8'h00);
        chk("mid_rst_tc", 8'(tc_status), 8'h00);
        HLDA = 1'b0;
        DREQ = 4'b0000;
        tick();
        RESET_n = 1'b1;
        tick();

        // Status clear coinciding with EOP
        DREQ = 4'b0100;
        wait_hrq(1'b1, 10, "st_hrq2");
        HLDA = 1'b1;
        tick();
        EOP_n = 1'b0;
        tick();
        chk("st_tc2", 8'(tc_status), 8'h04);
        EOP_n = 1'b1;
        HLDA  = 1'b0;
        DREQ  = 4'b1000;
        tick();
        wait_hrq(1'b1, 10, "st_hrq3");
        chk("st_act3", 8'(active_channel), 8'h03);
        HLDA = 1'b1;
        tick();
        EOP_n     = 1'b0;
        status_rd = 1'b1;
        tick();
        chk("st_set_wins", 8'(tc_status), 8'h08);
        EOP_n     = 1'b1;
        status_rd = 1'b0;
        HLDA      = 1'b0;
        DREQ      = 4'b0000;
        tick();
        status_rd = 1'b1;
        tick();
        status_rd = 1'b0;
        chk("st_clear", 8'(tc_status), 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
